cci_mpf_prim_ram_sc_byteena_fwd_init: RTL and testbench
=======================================================

Name: cci_mpf_prim_ram_sc_byteena_fwd_init

Overview:
- Single-clock, simple-dual-port, byte-masked RAM. Port A writes; port B reads.
- Contents initialize to a constant after reset, and again on request (reinit) without a reset.
- Same-cycle write/read collisions to one address are resolved by merging at byte level, so reads are always coherent.
- Used by MPF shims as tag and state storage that needs bulk clear plus coherent read-after-write.

Parameters:
N_ENTRIES, 32, number of words; power of 2, >= 2
N_DATA_BITS, 64, word width; multiple of N_BYTE_BITS
N_BYTE_BITS, 8, bits per byte-enable lane
N_OUTPUT_REG_STAGES, 0, extra read-data register stages (0..4)
INIT_VALUE, N_DATA_BITS'(0), value written to every entry during init
FORWARD_EN, 1, 1 = byte-merge same-cycle write data into colliding reads; 0 = colliding read returns old data

Ports:
clk0  in  1  clock, all logic
reset  in  1  synchronous, active-high
reinit  in  1  single-cycle pulse: re-run initialization
rdy  out  1  high when init is complete and ports are accepted
waddr  in  $clog2(N_ENTRIES)  write address
wen  in  1  write enable
byteena  in  N_DATA_BITS/N_BYTE_BITS  byte write mask, bit i covers bits [i*N_BYTE_BITS +: N_BYTE_BITS]
wdata  in  N_DATA_BITS  write data
raddr  in  $clog2(N_ENTRIES)  read address
ren  in  1  read request
rdata  out  N_DATA_BITS  read data
rdata_valid  out  1  rdata corresponds to an accepted read

Behaviour:
- Reset and clock: reset is synchronous, active-high; the clock is clk0.
- Reset values:
  - rdy = 0.
  - rdata_valid pipeline cleared to 0.
  - init address counter = 0.
  - rdata is undefined while rdata_valid = 0.
- FSM states: INIT and READY. Reset enters INIT.
- INIT:
  - Each cycle, write INIT_VALUE with all bytes enabled to init_addr, then increment init_addr.
  - On the cycle init_addr == N_ENTRIES-1 is written, transition to READY; rdy = 1 on the following cycle.
  - Init takes exactly N_ENTRIES cycles after reset deasserts.
  - User wen and ren are ignored: no write occurs, and rdata_valid stays 0 for those requests.
- READY:
  - Write: wen=1 writes the masked bytes of wdata to waddr at the clock edge. Bytes with byteena=0 keep their value. byteena=0 with wen=1 is a legal no-op.
  - Read: ren=1 at edge T produces rdata_valid=1 with data at edge T+1+N_OUTPUT_REG_STAGES.
  - Pipelining: one read accepted per cycle, no stalls; the valid pipeline tracks every stage.
  - Collision (wen && ren && waddr==raddr, same cycle), FORWARD_EN=1: the returned word takes enabled bytes from wdata and all other bytes from the stored word. The RAM runs in mixed-port OLD_DATA mode; the merge uses registered wdata, byteena and a collision flag applied after the RAM output stage.
  - Collision, FORWARD_EN=0: return the pre-write word.
  - A write at cycle T is visible to a non-colliding read of the same address issued at T+1.
- reinit:
  - reinit=1 in READY: rdy drops to 0 the next cycle; re-enter INIT with init_addr=0.
  - Reads already in the output pipeline drain normally with valid data.
  - A user write in the same cycle as reinit is still performed, then overwritten by init.
  - reinit=1 during INIT restarts the counter at 0.
  - reset takes priority over reinit.
- Reset during INIT or READY: immediately return to INIT at address 0 and clear rdata_valid.
- Address arithmetic: init_addr is $clog2(N_ENTRIES) bits; the terminal compare is made before the wrap, so it never wraps into user space.
- Static check: an elaboration error is raised if N_DATA_BITS % N_BYTE_BITS != 0.

Test Plan (N_ENTRIES=16, N_DATA_BITS=32, N_BYTE_BITS=8, INIT_VALUE=32'hA5A5A5A5, FORWARD_EN=1):
1. Release reset; ren=1 every cycle -> rdy rises exactly 16 cycles after reset falls; no rdata_valid before rdy; then reading all 16 addresses returns A5A5A5A5.
2. Write addr 3 with 11223344, byteena 4'b0101, then read addr 3 -> A522A544 one cycle after ren (stages=0); repeat with N_OUTPUT_REG_STAGES=2 -> same data, 3 cycles after ren.
3. Same cycle wen=1, ren=1, addr 5, wdata DEADBEEF, byteena 4'b1100 -> rdata DEADA5A5; with FORWARD_EN=0 -> A5A5A5A5; the next read of addr 5 -> DEADA5A5 in both cases.
4. Back-to-back reads of addrs 0..15, one per cycle, with random writes to other addresses -> 16 consecutive rdata_valid pulses, data matching the scoreboard.
5. Write FFFFFFFF to all entries, then pulse reinit -> rdy=0 next cycle, back to 1 after 16 cycles; all entries read A5A5A5A5; a write accepted with reinit is lost.
6. Assert reset at init_addr=7, and separately issue reinit at init_addr=7 -> in both cases rdy stays 0 for a full 16 further cycles; rdata_valid=0 throughout.

Source files
------------

// File: rtl/cci_mpf_prim_ram_sc_byteena_fwd_init.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_ram_sc_byteena_fwd_init
//
// Single-clock, simple-dual-port RAM with per-byte write enables. Port A
// writes and port B reads. After reset, or after a reinit pulse, every entry
// is written with INIT_VALUE, one entry per cycle. User traffic is accepted
// only while rdy is high.
//
// When a write and a read hit the same address in the same cycle, the RAM
// itself returns the old word. With FORWARD_EN=1 the enabled bytes of the
// write are merged into the read result after the RAM output register, so
// every read sees the newest data.
//
// Handshake: a request is accepted on a rising edge of clk0 when rdy=1 and
// wen/ren is high. There is no backpressure. An accepted read returns
// rdata with rdata_valid=1 exactly 1+N_OUTPUT_REG_STAGES cycles later.
// Requests presented while rdy=0 are dropped.
//
// Ports:
//   clk0        clock
//   reset       synchronous, active-high reset
//   reinit      one-cycle pulse that re-runs initialization
//   rdy         initialization complete, user ports accepted
//   waddr/wen/byteena/wdata   write port
//   raddr/ren                 read request
//   rdata/rdata_valid         read response
// ---------------------------------------------------------------------------
module cci_mpf_prim_ram_sc_byteena_fwd_init #(
  parameter int N_ENTRIES           = 32,
  parameter int N_DATA_BITS         = 64,
  parameter int N_BYTE_BITS         = 8,
  parameter int N_OUTPUT_REG_STAGES = 0,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = N_DATA_BITS'(0),
  parameter int FORWARD_EN          = 1
) (
  input  logic                                 clk0,
  input  logic                                 reset,
  input  logic                                 reinit,
  output logic                                 rdy,
  input  logic [$clog2(N_ENTRIES)-1:0]         waddr,
  input  logic                                 wen,
  input  logic [N_DATA_BITS/N_BYTE_BITS-1:0]   byteena,
  input  logic [N_DATA_BITS-1:0]               wdata,
  input  logic [$clog2(N_ENTRIES)-1:0]         raddr,
  input  logic                                 ren,
  output logic [N_DATA_BITS-1:0]               rdata,
  output logic                                 rdata_valid
);

  localparam int A_W  = $clog2(N_ENTRIES);
  localparam int N_BE = N_DATA_BITS / N_BYTE_BITS;

  if ((N_DATA_BITS % N_BYTE_BITS) != 0) begin : g_bad_byte_width
    $error("N_DATA_BITS must be a multiple of N_BYTE_BITS");
  end

  // -------------------------------------------------------------------------
  // Control FSM: INIT sweeps every address, READY accepts user traffic.
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [A_W-1:0] init_addr;
  logic [A_W-1:0] init_addr_nxt;

  always_ff @(posedge clk0) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    case (state)
      ST_INIT: begin
        if (reinit) begin
          init_addr_nxt = '0;
        end else if (init_addr == A_W'(N_ENTRIES - 1)) begin
          // Terminal compare happens before the increment, so the counter
          // is parked at 0 instead of wrapping.
          state_nxt     = ST_READY;
          init_addr_nxt = '0;
        end else begin
          init_addr_nxt = init_addr + 1'b1;
        end
      end
      ST_READY: begin
        if (reinit) begin
          state_nxt     = ST_INIT;
          init_addr_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_INIT;
        init_addr_nxt = '0;
      end
    endcase
  end

  assign rdy = (state == ST_READY);

  // -------------------------------------------------------------------------
  // Write port mux: the init sweep owns the write port while in INIT.
  // -------------------------------------------------------------------------
  logic                   mem_we;
  logic [A_W-1:0]         mem_addr;
  logic [N_DATA_BITS-1:0] mem_wdata;
  logic [N_BE-1:0]        mem_be;
  logic                   read_ok;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    mem_be    = byteena;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr;
      mem_wdata = INIT_VALUE;
      mem_be    = '1;
    end else begin
      mem_we    = wen;
    end
  end

  assign read_ok = rdy && ren;

  // -------------------------------------------------------------------------
  // Storage. The read register samples the array before this edge's write
  // lands, giving old-data behaviour on a same-address collision.
  // -------------------------------------------------------------------------
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [N_DATA_BITS-1:0] ram_q;

  always_ff @(posedge clk0) begin
    if (mem_we) begin
      for (int i = 0; i < N_BE; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*N_BYTE_BITS +: N_BYTE_BITS] <=
            mem_wdata[i*N_BYTE_BITS +: N_BYTE_BITS];
        end
      end
    end
    if (read_ok) begin
      ram_q <= mem[raddr];
    end
  end

  // -------------------------------------------------------------------------
  // First read stage: valid bit plus the write side-band needed to merge a
  // colliding write into the old word.
  // -------------------------------------------------------------------------
  logic                   rd_valid0;
  logic                   coll_q;
  logic [N_DATA_BITS-1:0] wdata_q;
  logic [N_BE-1:0]        be_q;
  logic [N_DATA_BITS-1:0] merged;

  always_ff @(posedge clk0) begin
    if (reset) begin
      rd_valid0 <= 1'b0;
    end else begin
      rd_valid0 <= read_ok;
    end
    if (read_ok) begin
      coll_q  <= (FORWARD_EN != 0) && wen && (waddr == raddr);
      wdata_q <= wdata;
      be_q    <= byteena;
    end
  end

  always_comb begin
    merged = ram_q;
    if (coll_q) begin
      for (int i = 0; i < N_BE; i++) begin
        if (be_q[i]) begin
          merged[i*N_BYTE_BITS +: N_BYTE_BITS] = wdata_q[i*N_BYTE_BITS +: N_BYTE_BITS];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional output register stages; the valid bit travels with the data.
  // -------------------------------------------------------------------------
  if (N_OUTPUT_REG_STAGES == 0) begin : g_no_out_reg
    assign rdata       = merged;
    assign rdata_valid = rd_valid0;
  end else begin : g_out_reg
    logic [N_DATA_BITS-1:0]         d_pipe [N_OUTPUT_REG_STAGES];
    logic [N_OUTPUT_REG_STAGES-1:0] v_pipe;

    always_ff @(posedge clk0) begin
      if (reset) begin
        v_pipe <= '0;
      end else begin
        v_pipe[0] <= rd_valid0;
        for (int i = 1; i < N_OUTPUT_REG_STAGES; i++) begin
          v_pipe[i] <= v_pipe[i-1];
        end
      end
      d_pipe[0] <= merged;
      for (int i = 1; i < N_OUTPUT_REG_STAGES; i++) begin
        d_pipe[i] <= d_pipe[i-1];
      end
    end

    assign rdata       = d_pipe[N_OUTPUT_REG_STAGES-1];
    assign rdata_valid = v_pipe[N_OUTPUT_REG_STAGES-1];
  end

endmodule

// File: tb/tb_cci_mpf_prim_ram_sc_byteena_fwd_init.sv
// ---------------------------------------------------------------------------
// Bench for cci_mpf_prim_ram_sc_byteena_fwd_init. Three instances share one
// set of inputs: forwarding with 0 output stages, forwarding with 2 output
// stages, and no forwarding with 0 output stages. Each instance has its own
// expected queue (data plus the cycle the response is due) and a monitor
// that pops on every rdata_valid.
// ---------------------------------------------------------------------------
module tb_cci_mpf_prim_ram_sc_byteena_fwd_init;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  // ---------------- clock / reset ----------------
  logic clk0 = 1'b0;
  logic reset;
  always #5 clk0 = ~clk0;

  int cyc = 0;
  always @(posedge clk0) cyc++;

  logic        reinit, wen, ren;
  logic [3:0]  waddr, raddr, byteena;
  logic [31:0] wdata;
  logic        rdy0, rdy2, rdyn;
  logic [31:0] rd0, rd2, rdn;
  logic        v0, v2, vn;

  cci_mpf_prim_ram_sc_byteena_fwd_init #(
    .N_ENTRIES(16), .N_DATA_BITS(32), .N_BYTE_BITS(8),
    .N_OUTPUT_REG_STAGES(0), .INIT_VALUE(IV), .FORWARD_EN(1)
  ) dut_s0 (
    .clk0(clk0), .reset(reset), .reinit(reinit), .rdy(rdy0),
    .waddr(waddr), .wen(wen), .byteena(byteena), .wdata(wdata),
    .raddr(raddr), .ren(ren), .rdata(rd0), .rdata_valid(v0)
  );

  cci_mpf_prim_ram_sc_byteena_fwd_init #(
    .N_ENTRIES(16), .N_DATA_BITS(32), .N_BYTE_BITS(8),
    .N_OUTPUT_REG_STAGES(2), .INIT_VALUE(IV), .FORWARD_EN(1)
  ) dut_s2 (
    .clk0(clk0), .reset(reset), .reinit(reinit), .rdy(rdy2),
    .waddr(waddr), .wen(wen), .byteena(byteena), .wdata(wdata),
    .raddr(raddr), .ren(ren), .rdata(rd2), .rdata_valid(v2)
  );

  cci_mpf_prim_ram_sc_byteena_fwd_init #(
    .N_ENTRIES(16), .N_DATA_BITS(32), .N_BYTE_BITS(8),
    .N_OUTPUT_REG_STAGES(0), .INIT_VALUE(IV), .FORWARD_EN(0)
  ) dut_nf (
    .clk0(clk0), .reset(reset), .reinit(reinit), .rdy(rdyn),
    .waddr(waddr), .wen(wen), .byteena(byteena), .wdata(wdata),
    .raddr(raddr), .ren(ren), .rdata(rdn), .rdata_valid(vn)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q0[$], exp_q2[$], exp_qn[$];
  int          due_q0[$], due_q2[$], due_qn[$];
  logic [31:0] model [16];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk0) begin : mon_s0
    logic [31:0] e;
    int d;
    if (v0 === 1'b1) begin
      n_cmp++;
      if (exp_q0.size() == 0) begin
        n_fail++;
        $display("FAIL s0_read: unexpected rdata_valid, rdata %h at cyc %0d", rd0, cyc);
      end else begin
        e = exp_q0.pop_front();
        d = due_q0.pop_front();
        if (rd0 !== e || cyc != d) begin
          n_fail++;
          $display("FAIL s0_read: got %h at cyc %0d want %h at cyc %0d", rd0, cyc, e, d);
        end
      end
    end
  end

  always @(negedge clk0) begin : mon_s2
    logic [31:0] e;
    int d;
    if (v2 === 1'b1) begin
      n_cmp++;
      if (exp_q2.size() == 0) begin
        n_fail++;
        $display("FAIL s2_read: unexpected rdata_valid, rdata %h at cyc %0d", rd2, cyc);
      end else begin
        e = exp_q2.pop_front();
        d = due_q2.pop_front();
        if (rd2 !== e || cyc != d) begin
          n_fail++;
          $display("FAIL s2_read: got %h at cyc %0d want %h at cyc %0d", rd2, cyc, e, d);
        end
      end
    end
  end

  always @(negedge clk0) begin : mon_nf
    logic [31:0] e;
    int d;
    if (vn === 1'b1) begin
      n_cmp++;
      if (exp_qn.size() == 0) begin
        n_fail++;
        $display("FAIL nf_read: unexpected rdata_valid, rdata %h at cyc %0d", rdn, cyc);
      end else begin
        e = exp_qn.pop_front();
        d = due_qn.pop_front();
        if (rdn !== e || cyc != d) begin
          n_fail++;
          $display("FAIL nf_read: got %h at cyc %0d want %h at cyc %0d", rdn, cyc, e, d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  // One cycle of user traffic. With use_exp set, the hand-computed values
  // exp_fw (forwarding instances) and exp_nf (non-forwarding instance) are
  // queued; otherwise the expectation comes from the bench's memory model.
  task automatic op(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic re, input logic [3:0] ra,
                    input logic use_exp, input logic [31:0] exp_fw,
                    input logic [31:0] exp_nf);
    logic [31:0] fw, nf;
    wen = we; waddr = wa; wdata = wd; byteena = be; ren = re; raddr = ra;
    if (rdy0 && re) begin
      nf = model[ra];
      fw = (we && wa == ra) ? merge(nf, wd, be) : nf;
      if (use_exp) begin
        fw = exp_fw;
        nf = exp_nf;
      end
      exp_q0.push_back(fw); due_q0.push_back(cyc + 1);
      exp_q2.push_back(fw); due_q2.push_back(cyc + 3);
      exp_qn.push_back(nf); due_qn.push_back(cyc + 1);
    end
    if (rdy0 && we) model[wa] = merge(model[wa], wd, be);
    step();
    wen = 1'b0; ren = 1'b0; byteena = 4'h0;
  endtask

  // Counts cycles until rdy rises, optionally issuing reads all along.
  task automatic count_to_rdy(input string name, input logic rd_during);
    int n;
    n = 0;
    while (!rdy0 && n < 40) begin
      if (rd_during) begin
        ren   = 1'b1;
        raddr = 4'($urandom_range(0, 15));
      end
      step();
      n++;
    end
    ren = 1'b0;
    check(name, n, 16);
    check({name, "_rdy_s2"}, {31'b0, rdy2}, 32'd1);
    check({name, "_rdy_nf"}, {31'b0, rdyn}, 32'd1);
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) model[i] = IV;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; reinit = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; byteena = '0; wdata = '0;
    model_init();
    repeat (3) step();
    check("reset_rdy", {31'b0, rdy0 | rdy2 | rdyn}, 32'd0);
    check("reset_valid", {31'b0, v0 | v2 | vn}, 32'd0);
    reset = 1'b0;

    // Init sweep with reads requested every cycle; none may be answered.
    count_to_rdy("init_cycles", 1'b1);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 1, IV, IV);

    // Partial write, then read back.
    op(1, 3, 32'h11223344, 4'b0101, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 3, 1, 32'hA522A544, 32'hA522A544);

    // Same-cycle collision, then a follow-up read.
    op(1, 5, 32'hDEADBEEF, 4'b1100, 1, 5, 1, 32'hDEADA5A5, 32'hA5A5A5A5);
    op(0, 0, 0, 0, 1, 5, 1, 32'hDEADA5A5, 32'hDEADA5A5);

    // Collision with an empty byte mask is a no-op write.
    op(1, 6, 32'hFFFFFFFF, 4'b0000, 1, 6, 1, IV, IV);
    op(0, 0, 0, 0, 1, 6, 1, IV, IV);

    // Back-to-back reads with writes to other addresses.
    for (int i = 0; i < 16; i++) begin
      op(1, 4'((i + $urandom_range(1, 15)) % 16), $urandom(),
         4'($urandom_range(0, 15)), 1, 4'(i), 0, 0, 0);
    end
    repeat (4) step();

    // Fill with ones, then reinit while a read is still in flight.
    for (int a = 0; a < 16; a++) op(1, 4'(a), 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wen = 1'b1; waddr = 4'd2; wdata = 32'h12345678; byteena = 4'hF; reinit = 1'b1;
    step();
    wen = 1'b0; reinit = 1'b0; byteena = 4'h0;
    model_init();
    check("reinit_rdy_drop", {31'b0, rdy0}, 32'd0);
    count_to_rdy("reinit_cycles", 1'b0);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 1, IV, IV);
    repeat (4) step();

    // Reset in the middle of the init sweep (init_addr = 7).
    reset = 1'b1; step(); reset = 1'b0;
    repeat (7) begin ren = 1'b1; raddr = 4'd7; step(); end
    reset = 1'b1; ren = 1'b1; step(); reset = 1'b0; ren = 1'b0;
    check("reset_mid_rdy", {31'b0, rdy0}, 32'd0);
    count_to_rdy("reset_mid_init", 1'b1);

    // Reinit in the middle of the init sweep (init_addr = 7).
    reinit = 1'b1; step(); reinit = 1'b0;
    repeat (7) begin ren = 1'b1; raddr = 4'd3; step(); end
    reinit = 1'b1; ren = 1'b1; step(); reinit = 1'b0; ren = 1'b0;
    check("reinit_mid_rdy", {31'b0, rdy0}, 32'd0);
    count_to_rdy("reinit_mid_init", 1'b1);
    op(0, 0, 0, 0, 1, 7, 1, IV, IV);
    op(0, 0, 0, 0, 1, 15, 1, IV, IV);

    repeat (6) step();
    check("q0_drained", exp_q0.size(), 0);
    check("q2_drained", exp_q2.size(), 0);
    check("qn_drained", exp_qn.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
